// File: rtl/mem_stream_loader.sv
// mem_stream_loader
//   Write-side front end for a 256x8 style memory. After a start request it
//   accepts `count` bytes over a valid/ready stream and writes them to
//   consecutive addresses from `base_addr`, wrapping at the top of memory.
//   `done` pulses once when the load completes.
//
//   Optional feature, enabled by defining LOADER_VERIFY_EN: after the last
//   write the loaded range is read back through mem_d_o. The read-back sum is
//   compared with the sum of the accepted bytes, and `err` flags a mismatch.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               load request, honoured only while idle
//   base_addr, count    first address and byte count (0..2**ADDR_W),
//                       latched on an accepted start
//   in_valid, in_data   byte stream input
//   in_ready            stream ready; high throughout the write phase
//   mem_we, mem_addr,
//   mem_d_i             registered memory write port
//   mem_d_o             memory read data (verify feature only)
//   busy                high whenever the loader is not idle
//   done                one-cycle completion pulse
//   err                 verify mismatch, held until the next accepted start
module mem_stream_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d_i,
    input  logic [DATA_W-1:0] mem_d_o,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {StIdle, StWrite, StFlush, StDone, StVerify} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWrite, StFlush, StDone} state_e;
`endif

    localparam logic [ADDR_W:0] RemOne = 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     rem_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_d_q;
    logic                hs;

    assign hs = in_valid & in_ready;

`ifdef LOADER_VERIFY_EN
    logic [DATA_W-1:0]   sum_q;
    logic [DATA_W-1:0]   vsum_q;
    logic [DATA_W-1:0]   vsum_nxt;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     cnt_q;
    logic                phase_q;
    logic                err_q;

    assign vsum_nxt = vsum_q + mem_d_o;
    assign err      = err_q;
`else
    logic unused_mem_d_o;
    assign unused_mem_d_o = ^mem_d_o;
    assign err            = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            // An empty load still passes through FLUSH so done keeps the same
            // two-cycle spacing from start as the final write does.
            StIdle:  if (start) state_d = (count == '0) ? StFlush : StWrite;
            StWrite: if (hs && rem_q == RemOne) state_d = StFlush;
`ifdef LOADER_VERIFY_EN
            StFlush: state_d = (cnt_q == '0) ? StDone : StVerify;
            StVerify: if (phase_q && rem_q == RemOne) state_d = StDone;
`else
            StFlush: state_d = StDone;
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == StWrite);
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_d_i  = mem_d_q;

    // Datapath: pointer, remaining count and registered memory port
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            rem_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_d_q    <= '0;
`ifdef LOADER_VERIFY_EN
            sum_q      <= '0;
            vsum_q     <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ptr_q <= base_addr;
                        rem_q <= count;
`ifdef LOADER_VERIFY_EN
                        base_q <= base_addr;
                        cnt_q  <= count;
                        sum_q  <= '0;
                        err_q  <= 1'b0;
`endif
                    end
                end
                StWrite: begin
                    if (hs) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= ptr_q;
                        mem_d_q    <= in_data;
                        ptr_q      <= ptr_q + 1'b1;
                        rem_q      <= rem_q - 1'b1;
`ifdef LOADER_VERIFY_EN
                        sum_q      <= sum_q + in_data;
`endif
                    end
                end
`ifdef LOADER_VERIFY_EN
                StFlush: begin
                    // Rewind for the read-back walk
                    if (cnt_q != '0) begin
                        ptr_q      <= base_q;
                        rem_q      <= cnt_q;
                        mem_addr_q <= base_q;
                        vsum_q     <= '0;
                        phase_q    <= 1'b0;
                    end
                end
                StVerify: begin
                    // Each address is held two cycles; the second cycle samples
                    // so a one-cycle registered read is also covered.
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q    <= 1'b0;
                        vsum_q     <= vsum_nxt;
                        ptr_q      <= ptr_q + 1'b1;
                        mem_addr_q <= ptr_q + 1'b1;
                        rem_q      <= rem_q - 1'b1;
                        if (rem_q == RemOne) begin
                            err_q <= (vsum_nxt != sum_q);
                        end
                    end
                end
`else
                StFlush: begin
                end
`endif
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Bench for mem_stream_loader: a byte-wide memory model, a queue of expected
// writes built from the stream handshakes, and checks on done timing, busy,
// in_ready and memory contents.
module tb_mem_stream_loader;

`ifdef LOADER_VERIFY_EN
    localparam bit VerifyEn = 1'b1;
`else
    localparam bit VerifyEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] count;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_d_i;
    logic [7:0] mem_d_o;
    logic       busy;
    logic       done;
    logic       err;

    mem_stream_loader #(
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .count    (count),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_d_i  (mem_d_i),
        .mem_d_o  (mem_d_o),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model with combinational read; force_zero corrupts read data.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] stim    [256];
    bit         force_zero = 1'b0;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_d_i;
    assign mem_d_o = force_zero ? 8'h00 : mem[mem_addr];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected writes: {cycle, addr, data}
    logic [47:0] exp_q [$];
    int          wr_cnt       = 0;
    int          done_cnt     = 0;
    int          done_cyc     = 0;
    logic        done_err     = 1'b0;
    logic [7:0]  last_wr_addr = 8'h00;

    always @(negedge clk) begin
        logic [47:0] e;
        if (mem_we) begin
            wr_cnt++;
            last_wr_addr = mem_addr;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_cycle", cyc, e[47:16]);
                check("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
                check("wr_data", {24'd0, mem_d_i}, {24'd0, e[7:0]});
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end
    end

    // Called at #1 after a rising edge with the loader idle; returns likewise.
    task automatic run_load(input logic [7:0] b, input int n, input int gap_at,
                            input int gap_len, input int restart_at, input int abort_at,
                            input bit rnd_gaps, input bit corrupt);
        int         last_ref;
        int         d0;
        int         w0;
        int         budget;
        bit         aborted;
        logic [7:0] a;
        logic [7:0] sum8;
        logic       exp_err;
        d0         = done_cnt;
        w0         = wr_cnt;
        aborted    = 1'b0;
        sum8       = 8'h00;
        force_zero = corrupt;
        start      = 1'b1;
        base_addr  = b;
        count      = 9'(n);
        last_ref   = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("err_clear_on_start", {31'd0, err}, 32'd0);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                in_valid = 1'b0;
                rst      = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("abort_in_ready", {31'd0, in_ready}, 32'd0);
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_mem_we", {31'd0, mem_we}, 32'd0);
                aborted = 1'b1;
                break;
            end
            if (i == gap_at) begin
                in_valid = 1'b0;
                repeat (gap_len) begin @(posedge clk); #1; end
            end
            if (rnd_gaps && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            if (i == restart_at) begin
                start     = 1'b1;
                base_addr = 8'h80;
                count     = 9'd5;
            end
            @(negedge clk);
            check("in_ready_write", {31'd0, in_ready}, 32'd1);
            if (!in_ready) begin
                in_valid = 1'b0;
                start    = 1'b0;
                break;
            end
            a = b + 8'(i);
            exp_q.push_back({32'(cyc + 1), a, stim[i]});
            ref_mem[a] = stim[i];
            sum8       = sum8 + stim[i];
            last_ref   = cyc;
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (aborted) begin
            repeat (6) @(negedge clk);
            check("abort_no_done", done_cnt - d0, 32'd0);
        end else begin
            @(negedge clk);
            check("in_ready_after_last", {31'd0, in_ready}, 32'd0);
            budget = 0;
            while (done_cnt == d0 && budget < 2 * n + 10) begin
                @(negedge clk);
                budget++;
            end
            check("done_seen", done_cnt - d0, 32'd1);
            check("done_latency", done_cyc - last_ref, 32'(2 + (VerifyEn ? 2 * n : 0)));
            exp_err = VerifyEn && corrupt && (sum8 != 8'h00);
            check("err_at_done", {31'd0, done_err}, {31'd0, exp_err});
            @(negedge clk);
            check("busy_after_done", {31'd0, busy}, 32'd0);
            check("single_done", done_cnt - d0, 32'd1);
            check("write_count", wr_cnt - w0, 32'(n));
        end
        check("exp_queue_empty", exp_q.size(), 32'd0);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            a = b + 8'(i);
            check("readback", {24'd0, mem[a]}, {24'd0, ref_mem[a]});
        end
        force_zero = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 8'h00;
        count     = 9'd0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_d_i", {24'd0, mem_d_i}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back bytes from address 0
        stim[0] = 8'h00; stim[1] = 8'h3C; stim[2] = 8'hFF;
        run_load(8'h00, 3, -1, 0, -1, -1, 1'b0, 1'b0);

        // Wrap past 0xFF with a two-cycle gap after the second byte
        for (int i = 0; i < 4; i++) stim[i] = 8'hA1 + 8'(i);
        run_load(8'hFE, 4, 2, 2, -1, -1, 1'b0, 1'b0);

        // Empty load
        run_load(8'h33, 0, -1, 0, -1, -1, 1'b0, 1'b0);

        // Start while busy must be ignored
        for (int i = 0; i < 6; i++) stim[i] = 8'($urandom);
        run_load(8'h20, 6, -1, 0, 2, -1, 1'b0, 1'b0);

        // Reset after two of five bytes
        for (int i = 0; i < 5; i++) stim[i] = 8'($urandom);
        run_load(8'h50, 5, -1, 0, -1, 2, 1'b0, 1'b0);

        // Full-memory load from 0x10; final write lands at 0x0F
        for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
        run_load(8'h10, 256, -1, 0, -1, -1, 1'b0, 1'b0);
        check("full_last_addr", {24'd0, last_wr_addr}, 32'h0F);

        // Random loads with random stream gaps
        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(16, 1));
            for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
            run_load(8'($urandom), n, -1, 0, -1, -1, 1'b1, 1'b0);
        end

`ifdef LOADER_VERIFY_EN
        stim[0] = 8'h11; stim[1] = 8'h22;
        run_load(8'h40, 2, -1, 0, -1, -1, 1'b0, 1'b0);
        run_load(8'h40, 2, -1, 0, -1, -1, 1'b0, 1'b1);
        check("err_held_after_done", {31'd0, err}, 32'd1);
        stim[0] = 8'h5A;
        run_load(8'h60, 1, -1, 0, -1, -1, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
